// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: shared types, widths and helpers for the hazard/forwarding unit
package pipe_hazard_pkg;
  localparam int NUM_REGS = 32;
  localparam int RW = $clog2(NUM_REGS);
  localparam int ZERO_REG = 31;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          wr;
    logic          ld;
  } trk_entry_t;
  function automatic int sel_width(input int stages);
    return (stages + 1) > 2 ? $clog2(stages + 1) : 1;
  endfunction
endpackage

// File: rtl/hazard_match_cell.sv
// hazard_match_cell: youngest-producer forwarding select and load-use detect for one source
module hazard_match_cell
  import pipe_hazard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = sel_width(STAGES)
) (
  input  logic [RW-1:0]          i_src,
  input  logic                   i_used,
  input  trk_entry_t [STAGES:1]  i_trk,
  output logic [SW-1:0]          o_sel,
  output logic                   o_load_hazard
);
  logic w_live;
  assign w_live = i_used && (i_src != RW'(ZERO_REG));
  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    o_sel = SW'(FWD_RF);
    o_load_hazard = 1'b0;
    for (int s = STAGES; s >= 1; s--) begin
      if (w_live && i_trk[s].valid && i_trk[s].wr && i_trk[s].rd == i_src) begin
        o_sel = SW'(s);
        o_load_hazard = i_trk[s].ld && (s < LOAD_STAGE);
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: tracks in-flight destinations, selects forwarding stages and raises load-use stalls
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int NSRC       = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32,
  localparam int SW        = sel_width(STAGES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_issue_valid,
  input  logic [RW-1:0]        i_issue_rd,
  input  logic                 i_issue_regwrite,
  input  logic                 i_issue_is_load,
  input  logic                 i_flush,
  input  logic [NSRC*RW-1:0]   i_src_addr,
  input  logic [NSRC-1:0]      i_src_used,
  output logic                 o_stall,
  output logic [NSRC*SW-1:0]   o_fwd_sel,
  output logic [CNT_W-1:0]     o_stall_count,
  output logic [CNT_W-1:0]     o_flush_count
);
  trk_entry_t [STAGES:1] r_trk;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic [NSRC-1:0]       w_haz;
  logic                  w_issue;
  logic                  w_flush_cnt_en;
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    hazard_match_cell #(.STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE), .SW(SW)) u_cell (
      .i_src         (i_src_addr[k*RW +: RW]),
      .i_used        (i_src_used[k]),
      .i_trk         (r_trk),
      .o_sel         (o_fwd_sel[k*SW +: SW]),
      .o_load_hazard (w_haz[k])
    );
  end
  assign o_stall = (|w_haz) && i_issue_valid && !i_flush;
  assign w_issue = i_issue_valid && !o_stall && !i_flush;
  assign w_flush_cnt_en = i_flush && i_issue_valid;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trk       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_trk[1] <= '{valid: w_issue, rd: i_issue_rd, wr: i_issue_regwrite, ld: i_issue_is_load};
      for (int s = 2; s <= STAGES; s++) r_trk[s] <= r_trk[s-1];
      r_stall_cnt <= r_stall_cnt + CNT_W'(o_stall && !(&r_stall_cnt));
      r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush_cnt_en && !(&r_flush_cnt));
    end
  end
  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed checks of forwarding selects, load-use stalls and counters
module tb_pipe_hazard_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid, issue_regwrite, issue_is_load, flush;
  logic [4:0]  issue_rd;
  logic [14:0] src_addr;
  logic [2:0]  src_used;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic [3:0]  stall_count, flush_count;
  int          errs = 0;
  int          checks = 0;

  pipe_hazard_unit #(.CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_issue_regwrite(issue_regwrite), .i_issue_is_load(issue_is_load), .i_flush(flush),
    .i_src_addr(src_addr), .i_src_used(src_used), .o_stall(stall), .o_fwd_sel(fwd_sel),
    .o_stall_count(stall_count), .o_flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                       input logic fl, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [2:0] u);
    issue_valid = v; issue_rd = rd; issue_regwrite = wr; issue_is_load = ld; flush = fl;
    src_addr = {a2, a1, a0}; src_used = u;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    repeat (n) tick();
  endtask

  function automatic logic [1:0] fs(input int k);
    return fwd_sel[k*2 +: 2];
  endfunction

  initial begin
    repeat (2) begin
      drive(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
      tick();
    end
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'(fwd_sel), 0);
    chk("rst_scnt", 32'(stall_count), 0);
    chk("rst_fcnt", 32'(flush_count), 0);
    rst_n = 1'b1;
    idle(1);
    // forwarding walks 1, 2, 3, then falls back to the register file
    drive(1, 1, 1, 0, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 5, 1, 0, 0, 1, 0, 0, 3'b001);
    chk("add_fwd1", 32'(fs(0)), 1);
    chk("add_nostall", 32'(stall), 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 3'b001);
    chk("add_fwd2", 32'(fs(0)), 2);
    tick();
    chk("add_fwd3", 32'(fs(0)), 3);
    tick();
    chk("add_fwd0", 32'(fs(0)), 0);
    idle(3);
    // load-use on src1
    drive(1, 2, 1, 1, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 6, 1, 0, 0, 0, 2, 0, 3'b010);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_fwd_in_stall", 32'(fs(1)), 1);
    tick();
    chk("lu_scnt", 32'(stall_count), 1);
    chk("lu_fwd2", 32'(fs(1)), 2);
    chk("lu_release", 32'(stall), 0);
    idle(3);
    // youngest ALU producer hides older load
    drive(1, 3, 1, 1, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 0, 0, 0, 0, 3, 0, 3, 3'b101);
    chk("yng_fwd0", 32'(fs(0)), 1);
    chk("yng_fwd2", 32'(fs(2)), 1);
    chk("yng_stall", 32'(stall), 0);
    idle(3);
    // XZR and unused sources never match
    drive(1, 31, 1, 1, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 4, 1, 1, 0, 31, 0, 0, 3'b001);
    chk("xzr_fwd", 32'(fs(0)), 0);
    chk("xzr_stall", 32'(stall), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 4, 31, 3'b100);
    chk("unused_fwd1", 32'(fs(1)), 0);
    chk("xzr_fwd2", 32'(fs(2)), 0);
    chk("unused_stall", 32'(stall), 0);
    idle(3);
    // younger load in front of older ALU result still stalls
    drive(1, 7, 1, 0, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 7, 1, 1, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 0, 0, 0, 0, 7, 0, 0, 3'b001);
    chk("hid_stall", 32'(stall), 1);
    chk("hid_fwd", 32'(fs(0)), 1);
    tick();
    chk("hid_release", 32'(stall), 0);
    chk("hid_fwd2", 32'(fs(0)), 2);
    chk("hid_scnt", 32'(stall_count), 2);
    idle(3);
    // flush beats stall and leaves a bubble
    drive(1, 8, 1, 1, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 9, 1, 0, 1, 8, 0, 0, 3'b001);
    chk("fl_stall", 32'(stall), 0);
    tick();
    drive(1, 0, 0, 0, 0, 8, 9, 0, 3'b011);
    chk("fl_fcnt", 32'(flush_count), 1);
    chk("fl_scnt", 32'(stall_count), 2);
    chk("fl_bubble", 32'(fs(1)), 0);
    chk("fl_fwd_ld", 32'(fs(0)), 2);
    chk("fl_nostall", 32'(stall), 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 3'b000);
    tick();
    chk("fl_invalid", 32'(flush_count), 1);
    idle(3);
    // saturation of the 4-bit stall counter
    for (int i = 1; i <= 18; i++) begin
      drive(1, 10, 1, 1, 0, 0, 0, 0, 3'b000);
      tick();
      drive(1, 0, 0, 0, 0, 10, 0, 0, 3'b001);
      tick();
      tick();
      if (i == 13) chk("sat_reach", 32'(stall_count), 15);
    end
    chk("sat_hold", 32'(stall_count), 15);
    idle(3);
    // async reset mid-stall
    drive(1, 11, 1, 1, 0, 0, 0, 0, 3'b000);
    tick();
    drive(1, 0, 0, 0, 0, 11, 0, 0, 3'b001);
    chk("mid_stall", 32'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_scnt", 32'(stall_count), 0);
    chk("mid_rst_fwd", 32'(fs(0)), 0);
    #1 rst_n = 1'b1;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
